// File: rtl/unpool_upsample2x.sv
// ============================================================================
// unpool_upsample2x : nearest-neighbour 2x2 upsampler for a pooled pixel stream
// Revision 1.0
// ============================================================================
`default_nettype none

module unpool_upsample2x #(
  parameter int In_d_W = 32,
  parameter int W      = 26
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [In_d_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [In_d_W-1:0] out_data,
  output logic                     out_last
);

  localparam int WH = W / 2;
  localparam int CW = $clog2(W) + 1;
  localparam int IW = (WH > 1) ? $clog2(WH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(WH - 1);

  typedef enum logic {
    S_TOP = 1'b0,
    S_BOT = 1'b1
  } state_t;

  state_t                     state;
  logic [CW-1:0]              col;
  logic                       phase;
  logic signed [In_d_W-1:0]   hold;
  logic signed [In_d_W-1:0]   linebuf [WH];
  logic                       accept;
  logic [IW-1:0]              idx;

  assign in_ready = clr_n && (state == S_TOP) && !phase;
  assign accept   = in_valid && in_ready;
  assign idx      = col[IW-1:0];

  // Storage is never reset: every entry is written in the top row before the bottom row reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf[idx] <= in_data;
      hold         <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= S_TOP;
      col       <= '0;
      phase     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_TOP: begin
          if (phase) begin
            out_data  <= hold;
            out_valid <= 1'b1;
            phase     <= 1'b0;
            if (col == LAST_COL) begin
              out_last <= 1'b1;
              col      <= '0;
              state    <= S_BOT;
            end else begin
              out_last <= 1'b0;
              col      <= col + 1'b1;
            end
          end else if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            phase     <= 1'b1;
          end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        S_BOT: begin
          // Each stored pixel is emitted twice, back to back.
          out_data  <= linebuf[idx];
          out_valid <= 1'b1;
          phase     <= ~phase;
          if (phase && (col == LAST_COL)) begin
            out_last <= 1'b1;
            col      <= '0;
            state    <= S_TOP;
          end else begin
            out_last <= 1'b0;
            if (phase) col <= col + 1'b1;
          end
        end
        default: begin
          state     <= S_TOP;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
